uart_regbank: RTL and testbench
===============================

Name: uart_regbank

Overview:
- Parametrised multi-channel UART register bank; successor to the single-UART register block.
- Sits on the CPU register bus as a 64 KB slave window and provides NUM_CH independent TX/RX FIFO channels.
- Adds features the single-UART block lacks: per-channel status, sticky overflow flags, RX fill level, and a maskable level interrupt to the CPU.

Parameters:
- NUM_CH, 2, number of UART channels, legal range 1..4.
- FIFO_DEPTH, 16, entries per FIFO; power of 2, legal range 4..256.
- DATA_W, 8, bits per character; legal range 5..8.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- request  in  1  bus access strobe, one cycle per access.
- address  in  16  byte address within the window.
- write  in  1  1 = write, 0 = read.
- wstrb  in  4  byte-lane enables for writes.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- ack  out  1  access acknowledge.
- uart_rx_complete  in  NUM_CH  per-channel pulse: a received character is on uart_rx_data.
- uart_rx_data  in  NUM_CH*DATA_W  received characters; channel n occupies bits [n*DATA_W +: DATA_W].
- uart_tx_valid  out  NUM_CH  TX FIFO of that channel is non-empty.
- uart_tx_data  out  NUM_CH*DATA_W  head of each TX FIFO (first-word-fall-through).
- uart_tx_complete  in  NUM_CH  pulse: head character has been sent; pops the TX FIFO.
- irq  out  1  level interrupt, registered.

Behaviour:
- Reset values:
  - rdata = 0, ack = 0, irq = 0.
  - All FIFOs empty, so uart_tx_valid = 0 and uart_tx_data = 0.
  - IRQ_EN = 0; all sticky flags = 0.
- Bus timing:
  - ack <= request every cycle, giving fixed 1-cycle latency.
  - rdata is valid in the ack cycle and is 0 on every cycle with no read.
  - Unmapped reads return 0; unmapped writes are ignored.
- Channel n registers at base n*0x10:
  - +0x0 TX
    - Write with wstrb[0]=1 pushes wdata[DATA_W-1:0].
    - If the FIFO is full, the write is dropped and TX_OVF is set.
    - Read returns the free slot count, 0..FIFO_DEPTH.
  - +0x4 RX
    - Read while non-empty returns the zero-extended head character and pops it the same cycle.
    - Read while empty returns 32'hFFFFFFFF and has no side effect.
    - Writes are ignored.
  - +0x8 STATUS
    - Read bits: bit0 RX non-empty, bit1 TX full, bit2 TX empty, bit3 RX_OVF (sticky), bit4 TX_OVF (sticky).
    - Write with wstrb[0]=1: bits 3 and 4 are write-1-to-clear; other bits ignored.
  - +0xC RXCOUNT
    - Read returns the RX fill level, 0..FIFO_DEPTH.
  - Addresses for channel indices >= NUM_CH are unmapped.
- Global registers:
  - 0x100 IRQ_EN (R/W, wstrb[0]): bit n enables RX non-empty of channel n; bit 4+n enables TX empty of channel n. Unused bits read 0.
  - 0x104 IRQ_PEND (read-only, live): bit n = RX non-empty(n) OR RX_OVF(n); bit 4+n = TX empty(n).
  - irq <= |(IRQ_PEND & IRQ_EN), registered with 1-cycle lag.
- RX line side:
  - uart_rx_complete on a full FIFO drops the character and sets RX_OVF.
  - Exception: if a CPU RX pop happens in the same cycle, the pop and push both occur and no overflow is flagged.
- Simultaneous events:
  - Push and pop in the same cycle on a non-empty, non-full FIFO: count is unchanged, pointers both advance.
  - Push on an empty FIFO while the CPU reads RX: the read returns FFFFFFFF; the push is accepted.
  - uart_tx_complete on an empty TX FIFO is ignored.
  - A sticky set and a W1C clear of the same bit in one cycle: set wins.
- Pointer arithmetic:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Count is log2(FIFO_DEPTH)+1 bits, so full is distinguishable from empty.
- Reset asserted mid-operation clears all FIFOs and flags immediately; in-flight reads are not acked.

Decomposition:
- Shared package uart_regbank_pkg holds:
  - register offset constants: OFF_TX, OFF_RX, OFF_STATUS, OFF_RXCOUNT, ADDR_IRQ_EN, ADDR_IRQ_PEND;
  - the CH_STRIDE constant;
  - STATUS bit-index constants.
- One natural sub-module: sync_fifo (params WIDTH, DEPTH). It is first-word-fall-through, has outputs count and not_empty, and has an asynchronous reset. The bank instantiates 2*NUM_CH copies of it via generate.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8, 0xC of channel 0:
  - responses: 16, FFFFFFFF, 0x00000004, 0;
  - ack asserted 1 cycle after each request.
- Write 17 chars 0x41.. to channel 1 TX (0x10) with no uart_tx_complete:
  - 0x10 reads 0;
  - STATUS 0x18 = 0x12 (TX full plus TX_OVF);
  - uart_tx_data[15:8] = 0x41.
- Pulse uart_tx_complete[1] 16 times:
  - uart_tx_data steps 0x41..0x50;
  - uart_tx_valid[1] falls after the 16th pulse;
  - writing 0x10 to 0x18 clears TX_OVF, and STATUS then reads 0x04.
- Push 17 RX chars on channel 0:
  - RXCOUNT = 16, STATUS bit3 = 1;
  - 16 reads of 0x4 return the first 16 chars in order, then FFFFFFFF.
- With RX full, assert uart_rx_complete[0] in the same cycle as a CPU read of 0x4:
  - head returned, RXCOUNT stays 16, RX_OVF stays 0.
- IRQ_EN = 0x10, then set IRQ_EN = 0x01 and push one RX char:
  - under 0x10 with TX empty, irq = 1 two cycles after the write;
  - after IRQ_EN = 0x01 and the RX push, irq = 1;
  - reading the char drops irq 2 cycles later;
  - reset asserted asynchronously drops irq immediately.

Source files
------------

// File: rtl/uart_regbank_pkg.sv
// rtl/uart_regbank_pkg.sv - register map and STATUS bit positions for the UART bank
package uart_regbank_pkg;

  localparam int CH_STRIDE = 16;

  localparam logic [3:0] OFF_TX      = 4'h0;
  localparam logic [3:0] OFF_RX      = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_RXCOUNT = 4'hC;

  localparam logic [15:0] ADDR_IRQ_EN   = 16'h0100;
  localparam logic [15:0] ADDR_IRQ_PEND = 16'h0104;

  localparam int ST_RX_NE    = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_TX_OVF   = 4;

endpackage

// File: rtl/uart_regbank_fifo.sv
// rtl/uart_regbank_fifo.sv - first-word-fall-through FIFO with fill count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   not_empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push   = push && (!full || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_regbank.sv
// rtl/uart_regbank.sv - multi-channel UART TX/RX FIFO register bank with maskable irq
module uart_regbank
  import uart_regbank_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request,
  input  logic [15:0]              address,
  input  logic                     write,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ack,
  input  logic [NUM_CH-1:0]        uart_rx_complete,
  input  logic [NUM_CH*DATA_W-1:0] uart_rx_data,
  output logic [NUM_CH-1:0]        uart_tx_valid,
  output logic [NUM_CH*DATA_W-1:0] uart_tx_data,
  input  logic [NUM_CH-1:0]        uart_tx_complete,
  output logic                     irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic              ch_region;
  logic [1:0]        ch_idx;
  logic [3:0]        off;
  logic              rd;
  logic              wr_lane0;
  logic [31:0]       rd_val;
  logic [7:0]        irq_en;
  logic [7:0]        irq_pend;
  logic [7:0]        irq_en_mask;
  logic              unused_bits;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] tx_push;
  logic [NUM_CH-1:0] rx_pop;
  logic [NUM_CH-1:0] status_wr;
  logic [NUM_CH-1:0] tx_ne;
  logic [NUM_CH-1:0] tx_full;
  logic [NUM_CH-1:0] rx_ne;
  logic [NUM_CH-1:0] rx_full;
  logic [NUM_CH-1:0] rx_ovf;
  logic [CW-1:0]     tx_count [NUM_CH];
  logic [CW-1:0]     rx_count [NUM_CH];
  logic [DATA_W-1:0] rx_head  [NUM_CH];
  logic [31:0]       status   [NUM_CH];

  // Only word-aligned offsets inside implemented channels decode; everything else is unmapped.
  assign ch_region   = (int'(address) < NUM_CH * CH_STRIDE) && (address[1:0] == 2'b00);
  assign ch_idx      = address[5:4];
  assign off         = address[3:0];
  assign rd          = request && !write;
  assign wr_lane0    = request && write && wstrb[0];
  assign unused_bits = ^{wstrb[3:1], wdata[31:8]};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic tx_ovf_q;
    logic rx_ovf_q;

    assign sel[n]       = ch_region && (int'(ch_idx) == n);
    assign tx_push[n]   = wr_lane0 && sel[n] && (off == OFF_TX);
    assign rx_pop[n]    = rd && sel[n] && (off == OFF_RX);
    assign status_wr[n] = wr_lane0 && sel[n] && (off == OFF_STATUS);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tx_push[n]),
      .push_data (wdata[DATA_W-1:0]),
      .pop       (uart_tx_complete[n]),
      .head      (uart_tx_data[n*DATA_W +: DATA_W]),
      .count     (tx_count[n]),
      .not_empty (tx_ne[n]),
      .full      (tx_full[n])
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (uart_rx_complete[n]),
      .push_data (uart_rx_data[n*DATA_W +: DATA_W]),
      .pop       (rx_pop[n]),
      .head      (rx_head[n]),
      .count     (rx_count[n]),
      .not_empty (rx_ne[n]),
      .full      (rx_full[n])
    );

    // Overflow set terms take priority over the write-1-to-clear from STATUS.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tx_ovf_q <= 1'b0;
        rx_ovf_q <= 1'b0;
      end else begin
        tx_ovf_q <= (tx_push[n] && tx_full[n] && !uart_tx_complete[n]) ||
                    (tx_ovf_q && !(status_wr[n] && wdata[ST_TX_OVF]));
        rx_ovf_q <= (uart_rx_complete[n] && rx_full[n] && !rx_pop[n]) ||
                    (rx_ovf_q && !(status_wr[n] && wdata[ST_RX_OVF]));
      end
    end

    assign rx_ovf[n]        = rx_ovf_q;
    assign uart_tx_valid[n] = tx_ne[n];
    assign status[n]        = {27'd0, tx_ovf_q, rx_ovf_q, !tx_ne[n], tx_full[n], rx_ne[n]};
  end

  always_comb begin
    irq_pend    = '0;
    irq_en_mask = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      irq_pend[n]      = rx_ne[n] || rx_ovf[n];
      irq_pend[4+n]    = !tx_ne[n];
      irq_en_mask[n]   = 1'b1;
      irq_en_mask[4+n] = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (ch_region) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (int'(ch_idx) == n) begin
          case (off)
            OFF_TX:      rd_val = 32'(CW'(FIFO_DEPTH) - tx_count[n]);
            OFF_RX:      rd_val = rx_ne[n] ? 32'(rx_head[n]) : 32'hFFFF_FFFF;
            OFF_STATUS:  rd_val = status[n];
            OFF_RXCOUNT: rd_val = 32'(rx_count[n]);
            default:     ;
          endcase
        end
      end
    end else if (address == ADDR_IRQ_EN) begin
      rd_val = 32'(irq_en);
    end else if (address == ADDR_IRQ_PEND) begin
      rd_val = 32'(irq_pend);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack    <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
      irq_en <= '0;
    end else begin
      ack   <= request;
      rdata <= rd ? rd_val : '0;
      irq   <= |(irq_pend & irq_en);
      if (wr_lane0 && (address == ADDR_IRQ_EN)) irq_en <= wdata[7:0] & irq_en_mask;
    end
  end

endmodule

// File: tb/tb_uart_regbank.sv
// tb/tb_uart_regbank.sv - self-checking bench for uart_regbank
module tb_uart_regbank;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int DW     = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 request;
  logic [15:0]          address;
  logic                 write;
  logic [3:0]           wstrb;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic                 ack;
  logic [NUM_CH-1:0]    uart_rx_complete;
  logic [NUM_CH*DW-1:0] uart_rx_data;
  logic [NUM_CH-1:0]    uart_tx_valid;
  logic [NUM_CH*DW-1:0] uart_tx_data;
  logic [NUM_CH-1:0]    uart_tx_complete;
  logic                 irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  rxq [$];
  logic [7:0]  txq [$];
  logic        rx_ovf0;
  logic        tx_ovf1;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  uart_regbank #(.NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .request          (request),
    .address          (address),
    .write            (write),
    .wstrb            (wstrb),
    .wdata            (wdata),
    .rdata            (rdata),
    .ack              (ack),
    .uart_rx_complete (uart_rx_complete),
    .uart_rx_data     (uart_rx_data),
    .uart_tx_valid    (uart_tx_valid),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_complete (uart_tx_complete),
    .irq              (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus access; the expected rdata goes on the scoreboard at drive time.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string name);
    logic [31:0] e;
    request = 1'b1;
    write   = wr;
    address = addr;
    wdata   = data;
    wstrb   = 4'h1;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    request = 1'b0;
    write   = 1'b0;
    wdata   = '0;
    check({name, "_ack"}, 32'(ack), 32'd1);
    e = exp_q.pop_front();
    check(name, rdata, e);
  endtask

  function automatic logic [31:0] st_exp(input int ch);
    logic [31:0] s;
    s = '0;
    if (ch == 0) begin
      s[0] = (rxq.size() != 0);
      s[2] = 1'b1;
      s[3] = rx_ovf0;
    end else begin
      s[1] = (txq.size() == DEPTH);
      s[2] = (txq.size() == 0);
      s[4] = tx_ovf1;
    end
    return s;
  endfunction

  task automatic rx_push(input logic [7:0] d);
    if (rxq.size() < DEPTH) rxq.push_back(d);
    else rx_ovf0 = 1'b1;
    uart_rx_complete[0] = 1'b1;
    uart_rx_data[7:0]   = d;
    @(posedge clock);
    #1;
    uart_rx_complete[0] = 1'b0;
  endtask

  task automatic rx_read(input string name);
    logic [31:0] e;
    e = (rxq.size() != 0) ? 32'(rxq.pop_front()) : 32'hFFFF_FFFF;
    access(1'b0, 16'h0004, '0, e, name);
  endtask

  // CPU RX read and line-side push landing in the same cycle.
  task automatic rx_read_push(input logic [7:0] d, input string name);
    logic [31:0] e;
    e = (rxq.size() != 0) ? 32'(rxq.pop_front()) : 32'hFFFF_FFFF;
    if (rxq.size() < DEPTH) rxq.push_back(d);
    else rx_ovf0 = 1'b1;
    uart_rx_complete[0] = 1'b1;
    uart_rx_data[7:0]   = d;
    access(1'b0, 16'h0004, '0, e, name);
    uart_rx_complete[0] = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] d);
    if (txq.size() < DEPTH) txq.push_back(d);
    else tx_ovf1 = 1'b1;
    access(1'b1, 16'h0010, 32'(d), '0, "tx_wr");
  endtask

  task automatic tx_done();
    if (txq.size() != 0) void'(txq.pop_front());
    uart_tx_complete[1] = 1'b1;
    @(posedge clock);
    #1;
    uart_tx_complete[1] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; request = 1'b0; address = '0; write = 1'b0; wstrb = '0; wdata = '0;
    uart_rx_complete = '0; uart_rx_data = '0; uart_tx_complete = '0;
    rx_ovf0 = 1'b0; tx_ovf1 = 1'b0;

    vecs[0]  = '{1'b0, 16'h0000, 32'h0,  32'd16};
    vecs[1]  = '{1'b0, 16'h0004, 32'h0,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 16'h0008, 32'h0,  32'h0000_0004};
    vecs[3]  = '{1'b0, 16'h000C, 32'h0,  32'h0};
    vecs[4]  = '{1'b0, 16'h0018, 32'h0,  32'h0000_0004};
    vecs[5]  = '{1'b0, 16'h0028, 32'h0,  32'h0};
    vecs[6]  = '{1'b0, 16'h0100, 32'h0,  32'h0};
    vecs[7]  = '{1'b0, 16'h0104, 32'h0,  32'h0000_0030};
    vecs[8]  = '{1'b1, 16'h0100, 32'hFF, 32'h0};
    vecs[9]  = '{1'b0, 16'h0100, 32'h0,  32'h0000_0033};
    vecs[10] = '{1'b1, 16'h0100, 32'h0,  32'h0};
    vecs[11] = '{1'b1, 16'h0004, 32'h55, 32'h0};
    vecs[12] = '{1'b0, 16'h000C, 32'h0,  32'h0};
    vecs[13] = '{1'b0, 16'h0200, 32'h0,  32'h0};
    vecs[14] = '{1'b1, 16'h0020, 32'h41, 32'h0};
    vecs[15] = '{1'b0, 16'h0104, 32'h0,  32'h0000_0030};

    repeat (3) @(posedge clock);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 16; i++)
      access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));

    @(posedge clock);
    #1;
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_rdata", rdata, 32'd0);

    // TX: overfill channel 1, then drain it from the line side.
    for (int i = 0; i < 17; i++) tx_write(8'h41 + 8'(i));
    access(1'b0, 16'h0010, '0, 32'(DEPTH - txq.size()), "tx_free_full");
    access(1'b0, 16'h0018, '0, st_exp(1), "tx_status_full");
    check("tx_valid_full", 32'(uart_tx_valid[1]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_head%0d", i), 32'(uart_tx_data[15:8]), 32'(txq[0]));
      tx_done();
    end
    check("tx_valid_drained", 32'(uart_tx_valid[1]), 32'd0);
    check("tx_data_drained", 32'(uart_tx_data[15:8]), 32'd0);
    tx_done();
    access(1'b0, 16'h0010, '0, 32'(DEPTH - txq.size()), "tx_free_empty");
    access(1'b1, 16'h0018, 32'h10, '0, "tx_w1c");
    tx_ovf1 = 1'b0;
    access(1'b0, 16'h0018, '0, st_exp(1), "tx_status_clr");

    // RX: overfill channel 0 and drain it from the CPU side.
    for (int i = 0; i < 17; i++) rx_push(8'h61 + 8'(i));
    access(1'b0, 16'h000C, '0, 32'(rxq.size()), "rx_count_full");
    access(1'b0, 16'h0008, '0, st_exp(0), "rx_status_ovf");
    for (int i = 0; i < 17; i++) rx_read($sformatf("rx_rd%0d", i));
    access(1'b1, 16'h0008, 32'h08, '0, "rx_w1c");
    rx_ovf0 = 1'b0;
    access(1'b0, 16'h0008, '0, st_exp(0), "rx_status_clr");

    for (int i = 0; i < 16; i++) rx_push(8'h80 + 8'(i));
    rx_read_push(8'h90, "rx_rd_push_full");
    access(1'b0, 16'h000C, '0, 32'(rxq.size()), "rx_count_still_full");
    access(1'b0, 16'h0008, '0, st_exp(0), "rx_status_no_ovf");

    // Overflow set and W1C in the same cycle: the set survives.
    rx_ovf0 = 1'b1;
    uart_rx_complete[0] = 1'b1;
    uart_rx_data[7:0]   = 8'h91;
    access(1'b1, 16'h0008, 32'h08, '0, "rx_set_vs_clr");
    uart_rx_complete[0] = 1'b0;
    access(1'b0, 16'h0008, '0, st_exp(0), "rx_status_set_wins");
    access(1'b1, 16'h0008, 32'h08, '0, "rx_w1c2");
    rx_ovf0 = 1'b0;
    for (int i = 0; i < 17; i++) rx_read($sformatf("rx_drain%0d", i));
    rx_read_push(8'hA5, "rx_rd_push_empty");
    access(1'b0, 16'h000C, '0, 32'(rxq.size()), "rx_count_one");
    rx_read("rx_rd_a5");

    // Interrupt enable, pending and the registered one-cycle lag.
    access(1'b1, 16'h0100, 32'h10, '0, "irq_en_tx");
    check("irq_lag_tx0", 32'(irq), 32'd0);
    @(posedge clock);
    #1;
    check("irq_tx_empty", 32'(irq), 32'd1);
    access(1'b1, 16'h0100, 32'h01, '0, "irq_en_rx");
    @(posedge clock);
    #1;
    check("irq_rx_only_idle", 32'(irq), 32'd0);
    rx_push(8'hC3);
    check("irq_lag_rx0", 32'(irq), 32'd0);
    @(posedge clock);
    #1;
    check("irq_rx_pending", 32'(irq), 32'd1);
    rx_read("irq_rd_c3");
    check("irq_hold_after_rd", 32'(irq), 32'd1);
    @(posedge clock);
    #1;
    check("irq_dropped", 32'(irq), 32'd0);

    // Asynchronous reset mid-cycle, and a read issued under reset.
    tx_write(8'h77);
    rx_push(8'hD4);
    @(posedge clock);
    #1;
    check("irq_before_rst", 32'(irq), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("async_rst_tx_data", 32'(uart_tx_data), 32'd0);
    rxq.delete();
    txq.delete();
    rx_ovf0 = 1'b0;
    tx_ovf1 = 1'b0;
    request = 1'b1;
    address = 16'h0004;
    write   = 1'b0;
    @(posedge clock);
    #1;
    request = 1'b0;
    check("rst_inflight_ack", 32'(ack), 32'd0);
    check("rst_inflight_rdata", rdata, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    access(1'b0, 16'h000C, '0, 32'(rxq.size()), "post_rst_rxcount");
    access(1'b0, 16'h0018, '0, st_exp(1), "post_rst_status1");
    access(1'b0, 16'h0100, '0, 32'h0, "post_rst_irq_en");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
